// File: rtl/prog_loader.sv
// prog_loader: boot-time program loader for the 2-stage RV32I core.
// Turns a little-endian byte stream (count[7:0], count[15:8], count*4 data
// bytes) into one-cycle word writes on memEn/memAddr/memData. The processor
// is held in cpu_reset until the whole image is written.
// Optional checksum byte after the image: define PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int               WIDTH     = 32,
  parameter int               MAX_WORDS = 1024,
  parameter logic [WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  input  logic             restart,
  output logic             memEn,
  output logic [WIDTH-1:0] memAddr,
  output logic [WIDTH-1:0] memData,
  output logic             cpu_reset,
  output logic             load_done,
  output logic             load_error,
  output logic [15:0]      words_loaded
);

  typedef enum logic [2:0] {
    S_HDR_LO,
    S_HDR_HI,
    S_DATA,
    S_FLUSH,
    S_DONE,
    S_ERROR
`ifdef PROG_LOADER_CHECKSUM_EN
    , S_CHK
`endif
  } state_t;

  // State entered once the image payload (possibly empty) has been consumed.
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t S_TAIL = S_CHK;
`else
  localparam state_t S_TAIL = S_FLUSH;
`endif

  localparam logic [15:0] MAX_CNT = 16'(MAX_WORDS);

  state_t           state_q;
  logic [15:0]      count_q;
  logic [1:0]       idx_q;
  logic [WIDTH-1:0] asm_q;
  logic             pend_q;       // assembled word waiting for its write cycle
  logic             mem_en_q;
  logic [WIDTH-1:0] mem_addr_q;
  logic [WIDTH-1:0] mem_data_q;
  logic [15:0]      words_q;
  logic             cpu_reset_q;
  logic             load_done_q;
  logic             load_error_q;

  logic             accept;
  logic             last_word;
  logic             restart_ok;
  logic [15:0]      count_d;
  logic [WIDTH-1:0] asm_d;

  assign accept     = in_valid && in_ready;
  assign count_d    = {in_data, count_q[7:0]};
  // First data byte lands in the LSB once four bytes have shifted in.
  assign asm_d      = {in_data, asm_q[WIDTH-1:8]};
  // No write can be pending on a 4th byte: writes are at least four bytes apart.
  assign last_word  = (words_q + 16'd1) == count_q;
  assign restart_ok = restart && ((state_q == S_DONE) || (state_q == S_ERROR));

  // Byte acceptance is a pure decode of the state register; the loader never
  // stalls inside a byte-consuming state.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      S_HDR_LO, S_HDR_HI, S_DATA: in_ready = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHK:                      in_ready = 1'b1;
`endif
      default:                    in_ready = 1'b0;
    endcase
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] chk_q;

  // Running XOR of all frame bytes, restarted by the first header byte.
  always_ff @(posedge clock) begin
    if (!reset) begin
      chk_q <= '0;
    end else if (accept) begin
      chk_q <= (state_q == S_HDR_LO) ? in_data : (chk_q ^ in_data);
    end
  end
`endif

  // Frame-parsing FSM with registered status outputs.
  always_ff @(posedge clock) begin
    // NOTE: reset is sampled on the clock edge, and every register here uses
    // non-blocking assignment so all reads see pre-edge values.
    if (!reset) begin
      state_q      <= S_HDR_LO;
      count_q      <= '0;
      idx_q        <= '0;
      asm_q        <= '0;
      pend_q       <= 1'b0;
      cpu_reset_q  <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      pend_q <= 1'b0;
      case (state_q)
        S_HDR_LO: begin
          if (accept) begin
            count_q[7:0] <= in_data;
            state_q      <= S_HDR_HI;
          end
        end
        S_HDR_HI: begin
          if (accept) begin
            count_q <= count_d;
            idx_q   <= '0;
            if (count_d > MAX_CNT) begin
              state_q      <= S_ERROR;
              load_error_q <= 1'b1;
            end else if (count_d == 16'd0) begin
              state_q <= S_TAIL;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            asm_q <= asm_d;
            idx_q <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              pend_q <= 1'b1;
              if (last_word) state_q <= S_TAIL;
            end
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (accept) begin
            if (in_data == chk_q) begin
              state_q <= S_FLUSH;
            end else begin
              state_q      <= S_ERROR;
              load_error_q <= 1'b1;
            end
          end
        end
`endif
        S_FLUSH: begin
          // Leave only after the final write has issued plus one idle cycle.
          if (!pend_q && !mem_en_q) begin
            state_q     <= S_DONE;
            cpu_reset_q <= 1'b0;
            load_done_q <= 1'b1;
          end
        end
        S_DONE, S_ERROR: begin
          if (restart) begin
            state_q      <= S_HDR_LO;
            cpu_reset_q  <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
          end
        end
        default: state_q <= S_HDR_LO;
      endcase
    end
  end

  // Write port: one memEn pulse per assembled word, address from the word count.
  always_ff @(posedge clock) begin
    if (!reset) begin
      mem_en_q   <= 1'b0;
      mem_addr_q <= BASE_ADDR;
      mem_data_q <= '0;
      words_q    <= '0;
    end else begin
      mem_en_q <= pend_q;
      if (pend_q) begin
        mem_addr_q <= BASE_ADDR + WIDTH'({words_q, 2'b00});
        mem_data_q <= asm_q;
        words_q    <= words_q + 16'd1;
      end else if (restart_ok) begin
        mem_addr_q <= BASE_ADDR;
        words_q    <= '0;
      end
    end
  end

  assign memEn        = mem_en_q;
  assign memAddr      = mem_addr_q;
  assign memData      = mem_data_q;
  assign cpu_reset    = cpu_reset_q;
  assign load_done    = load_done_q;
  assign load_error   = load_error_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: self-checking bench for prog_loader. A frame-level model
// predicts every memory write (address, data, cycle) from the bytes sent;
// one compare process checks the write port and word count each cycle.
module tb_prog_loader;

  localparam int          WIDTH     = 32;
  localparam int          MAX_WORDS = 1024;
  localparam logic [31:0] BASE_ADDR = 32'h0;

  logic        clock    = 1'b0;
  logic        reset    = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data  = 8'h00;
  logic        restart  = 1'b0;
  logic        in_ready;
  logic        memEn;
  logic [31:0] memAddr;
  logic [31:0] memData;
  logic        cpu_reset;
  logic        load_done;
  logic        load_error;
  logic [15:0] words_loaded;

  prog_loader #(
    .WIDTH    (WIDTH),
    .MAX_WORDS(MAX_WORDS),
    .BASE_ADDR(BASE_ADDR)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .restart     (restart),
    .memEn       (memEn),
    .memAddr     (memAddr),
    .memData     (memData),
    .cpu_reset   (cpu_reset),
    .load_done   (load_done),
    .load_error  (load_error),
    .words_loaded(words_loaded)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          due;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] obs_addr[$];
  logic [31:0] obs_data[$];
  logic [31:0] img[$];
  logic [31:0] a_addr[$];
  logic [31:0] a_data[$];
  int          model_words = 0;
  int          acc_edge    = 0;
  int          exp_done    = -1;
`ifdef PROG_LOADER_CHECKSUM_EN
  int          chk_force   = -1;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every cycle: a write is due exactly when the model says, never otherwise.
  always begin : cmp
    wr_t e;
    @(posedge clock);
    #2;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      check("memEn", 32'(memEn), 32'd1);
      check("memAddr", memAddr, e.addr);
      check("memData", memData, e.data);
      model_words++;
    end else begin
      check("memEn_idle", 32'(memEn), 32'd0);
    end
    if (memEn) begin
      obs_addr.push_back(memAddr);
      obs_data.push_back(memData);
    end
    check("words_loaded", 32'(words_loaded), 32'(model_words));
  end

  // Present one byte (after random idle gaps) and hold it for one edge.
  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    while (int'($urandom_range(99)) < gap_pct) begin
      in_valid = 1'b0;
      @(negedge clock);
    end
    in_valid = 1'b1;
    in_data  = b;
    check("in_ready_load", 32'(in_ready), 32'd1);
    @(negedge clock);
    acc_edge = cyc;
    in_valid = 1'b0;
  endtask

  // Send header + img[0..cnt-1]; record expected writes and the DONE edge.
  task automatic send_frame(input logic [15:0] cnt, input int gap_pct);
    logic [31:0] w;
    int          flush_edge;
    int          last_due;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]  x;
    x = cnt[7:0] ^ cnt[15:8];
`endif
    exp_done = -1;
    send_byte(cnt[7:0], gap_pct);
    send_byte(cnt[15:8], gap_pct);
    flush_edge = acc_edge;
    last_due   = 0;
    if (cnt > 16'(MAX_WORDS)) return;
    for (int i = 0; i < int'(cnt); i++) begin
      w = img[i];
      for (int j = 0; j < 4; j++) begin
`ifdef PROG_LOADER_CHECKSUM_EN
        x ^= w[8*j +: 8];
`endif
        send_byte(w[8*j +: 8], gap_pct);
      end
      exp_q.push_back('{acc_edge + 1, BASE_ADDR + 32'(4 * i), w});
      last_due   = acc_edge + 1;
      flush_edge = acc_edge;
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte((chk_force < 0) ? x : chk_force[7:0], gap_pct);
    flush_edge = acc_edge;
    if (chk_force >= 0 && chk_force[7:0] != x) return;
`endif
    // One idle cycle after the final write pulse, or after the tail state.
    exp_done = (last_due + 2 > flush_edge + 1) ? last_due + 2 : flush_edge + 1;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!load_done && n < 64) begin
      @(posedge clock);
      #2;
      n++;
    end
    check({tag, "_done_edge"}, 32'(cyc), 32'(exp_done));
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_load_error"}, 32'(load_error), 32'd0);
    @(negedge clock);
  endtask

  task automatic do_restart();
    restart     = 1'b1;
    model_words = 0;
    @(negedge clock);
    restart = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_load_error", 32'(load_error), 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    check("rst_memAddr", memAddr, BASE_ADDR);
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    model_words = 0;
    @(negedge clock);
    check("por_in_ready", 32'(in_ready), 32'd1);
    check("por_memEn", 32'(memEn), 32'd0);
    check("por_memAddr", memAddr, BASE_ADDR);
    check("por_memData", memData, 32'h0);
    check("por_cpu_reset", 32'(cpu_reset), 32'd1);
    check("por_load_done", 32'(load_done), 32'd0);
    check("por_load_error", 32'(load_error), 32'd0);
    check("por_words", 32'(words_loaded), 32'd0);
    reset = 1'b1;
  endtask

  task automatic rand_img(input int n);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back($urandom());
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Global time limit so a stuck design still reaches the summary line.
  initial begin
    #1_000_000;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    @(negedge clock);
    do_reset();

    // Directed two-word image from the bring-up program.
    img = '{32'h09000513, 32'h0000006F};
    obs_addr.delete(); obs_data.delete();
    send_frame(16'd2, 0);
    wait_done("two_word");
    check("two_word_count", 32'(obs_addr.size()), 32'd2);
    if (obs_addr.size() == 2) begin
      check("two_word_addr0", obs_addr[0], 32'h0);
      check("two_word_data0", obs_data[0], 32'h09000513);
      check("two_word_addr1", obs_addr[1], 32'h4);
      check("two_word_data1", obs_data[1], 32'h0000006F);
    end
    check("two_word_words", 32'(words_loaded), 32'd2);
    // Trailing bytes in DONE are refused.
    in_valid = 1'b1; in_data = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("done_no_consume", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    do_restart();

    // Oversized header is rejected.
    send_frame(16'd1025, 0);
    check("err_load_error", 32'(load_error), 32'd1);
    check("err_cpu_reset", 32'(cpu_reset), 32'd1);
    check("err_in_ready", 32'(in_ready), 32'd0);
    check("err_load_done", 32'(load_done), 32'd0);
    idle(3);
    check("err_hold", 32'(load_error), 32'd1);
    do_restart();

    // Empty image.
    obs_addr.delete(); obs_data.delete();
    send_frame(16'd0, 0);
    wait_done("empty");
    check("empty_no_write", 32'(obs_addr.size()), 32'd0);
    do_restart();

    // 12 words without gaps, then the same image with 50% gaps.
    rand_img(12);
    obs_addr.delete(); obs_data.delete();
    send_frame(16'd12, 0);
    wait_done("w12_nogap");
    a_addr = obs_addr; a_data = obs_data;
    do_restart();
    obs_addr.delete(); obs_data.delete();
    send_frame(16'd12, 50);
    wait_done("w12_gap");
    check("w12_gap_count", 32'(obs_addr.size()), 32'(a_addr.size()));
    if (obs_addr.size() == a_addr.size()) begin
      for (int i = 0; i < a_addr.size(); i++) begin
        check("w12_gap_addr", obs_addr[i], a_addr[i]);
        check("w12_gap_data", obs_data[i], a_data[i]);
      end
    end
    do_restart();

    // Reset in the middle of DATA after 5 of 12 words.
    rand_img(12);
    send_byte(8'd12, 0);
    send_byte(8'd0, 0);
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 4; j++) send_byte(img[i][8*j +: 8], 0);
      exp_q.push_back('{acc_edge + 1, BASE_ADDR + 32'(4 * i), img[i]});
    end
    send_byte(img[5][7:0], 0);
    send_byte(img[5][15:8], 0);
    idle(3);
    do_reset();
    idle(4);
    rand_img(3);
    obs_addr.delete(); obs_data.delete();
    send_frame(16'd3, 20);
    wait_done("after_reset");
    check("after_reset_addr0", obs_addr.size() > 0 ? obs_addr[0] : 32'hFFFF_FFFF, 32'h0);
    check("after_reset_words", 32'(words_loaded), 32'd3);
    do_restart();

    // Random images with random gap density.
    for (int k = 0; k < 4; k++) begin
      int n;
      n = int'($urandom_range(1, 7));
      rand_img(n);
      send_frame(16'(n), int'($urandom_range(0, 70)));
      wait_done("random");
      do_restart();
    end

    // Largest legal image: last word lands at 4*(MAX_WORDS-1).
    rand_img(MAX_WORDS);
    obs_addr.delete(); obs_data.delete();
    send_frame(16'(MAX_WORDS), 0);
    wait_done("max");
    check("max_words", 32'(words_loaded), 32'd1024);
    check("max_last_addr", obs_addr.size() > 0 ? obs_addr[obs_addr.size() - 1] : 32'h0, 32'hFFC);
    do_restart();

`ifdef PROG_LOADER_CHECKSUM_EN
    // Good checksum: 01^00^11^22^33^44 = 0x45.
    img = '{32'h44332211};
    chk_force = 8'h45;
    obs_addr.delete(); obs_data.delete();
    send_frame(16'd1, 0);
    wait_done("chk_good");
    do_restart();
    // Bad checksum: word still written, processor stays in reset.
    chk_force = 8'h00;
    obs_addr.delete(); obs_data.delete();
    send_frame(16'd1, 0);
    idle(3);
    check("chk_bad_error", 32'(load_error), 32'd1);
    check("chk_bad_cpu_reset", 32'(cpu_reset), 32'd1);
    check("chk_bad_done", 32'(load_done), 32'd0);
    check("chk_bad_written", obs_data.size() > 0 ? obs_data[0] : 32'h0, 32'h44332211);
    check("chk_bad_addr", obs_addr.size() > 0 ? obs_addr[0] : 32'hFFFF_FFFF, 32'h0);
    chk_force = -1;
    do_restart();
`endif

    idle(2);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
